// File: rtl/and_gate_sync_pkg.sv
// Shared defaults for the and_gate_sync block and its interface.
package and_gate_sync_pkg;

    localparam int unsigned DEFAULT_WIDTH = 1;
    localparam int unsigned DEFAULT_CNT_W = 8;

endpackage

// File: rtl/and_gate_sync_if.sv
// Operand/result bundle for and_gate_sync; master drives operands, slave returns results.
interface and_gate_sync_if
    import and_gate_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             en;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             y_rise;
    logic             all_ones;
    logic [CNT_W-1:0] ones_cnt;

    modport master (
        output a, b, en,
        input  y, y_q, y_rise, all_ones, ones_cnt
    );

    modport slave (
        input  a, b, en,
        output y, y_q, y_rise, all_ones, ones_cnt
    );

endinterface

// File: rtl/and_gate_sync_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module and_gate_sync_sat_counter
    import and_gate_sync_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/and_gate_sync.sv
// Bitwise AND with a clock-free combinational result, an enabled registered copy,
// a 0->1 edge pulse and a saturating count of all-ones cycles.
module and_gate_sync
    import and_gate_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    and_gate_sync_if.slave  bus
);

    logic [WIDTH-1:0] y_d;
    logic             all_ones_d;
    logic [WIDTH-1:0] y_q;
    logic             y_rise_q;

    // Combinational path never touches clk/rst/en.
    assign y_d        = bus.a & bus.b;
    assign all_ones_d = &y_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            y_rise_q <= 1'b0;
        end else if (bus.en) begin
            y_q      <= y_d;
            y_rise_q <= |(~y_q & y_d);
        end else begin
            y_rise_q <= 1'b0;
        end
    end

    and_gate_sync_sat_counter #(
        .CNT_W (CNT_W)
    ) u_ones_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.en & all_ones_d),
        .count (bus.ones_cnt)
    );

    assign bus.y        = y_d;
    assign bus.all_ones = all_ones_d;
    assign bus.y_q      = y_q;
    assign bus.y_rise   = y_rise_q;

endmodule

// File: tb/tb_and_gate_sync.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_and_gate_sync;

    localparam int unsigned W    = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned MAXC = (1 << CW) - 1;
    localparam logic [W-1:0] ALL = '1;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic clk1 = 1'b0;
    logic rst1 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    and_gate_sync_if #(.WIDTH(1), .CNT_W(8))  bus1 ();
    and_gate_sync_if #(.WIDTH(W), .CNT_W(CW)) bus4 ();

    and_gate_sync #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk (clk1),
        .rst (rst1),
        .bus (bus1)
    );

    and_gate_sync #(.WIDTH(W), .CNT_W(CW)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: last enabled product, newly-set-bit pulse, saturating all-ones tally.
    logic [W-1:0] m_yq;
    bit           m_rise;
    int unsigned  m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_yq   = '0;
            m_rise = 1'b0;
            m_cnt  = 0;
        end else if (bus4.en) begin
            m_rise = ((bus4.a & bus4.b) & ~m_yq) != '0;
            m_yq   = bus4.a & bus4.b;
            if ((bus4.a & bus4.b) == ALL && m_cnt < MAXC) m_cnt++;
        end else begin
            m_rise = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("y",        32'(bus4.y),        32'(bus4.a & bus4.b));
            check("all_ones", 32'(bus4.all_ones), 32'((bus4.a & bus4.b) == ALL));
            check("y_q",      32'(bus4.y_q),      32'(m_yq));
            check("y_rise",   32'(bus4.y_rise),   32'(m_rise));
            check("ones_cnt", 32'(bus4.ones_cnt), m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] tt_exp;
        tt_exp = 4'b1000;
        bus4.a  = '0;
        bus4.b  = '0;
        bus4.en = 1'b0;

        // Truth table on the 1-bit instance, its clock never toggles.
        bus1.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus1.a = 1'(i >> 1);
            bus1.b = 1'(i);
            #10;
            check("tt_y",      32'(bus1.y),        32'(bus1.a & bus1.b));
            check("tt_lit",    32'(bus1.y),        32'(tt_exp[i]));
            check("tt_allone", 32'(bus1.all_ones), 32'(tt_exp[i]));
        end

        check("rst_y_q",  32'(bus4.y_q),      32'h0);
        check("rst_rise", 32'(bus4.y_rise),   32'h0);
        check("rst_cnt",  32'(bus4.ones_cnt), 32'h0);

        step();
        rst      = 1'b0;
        checking = 1'b1;

        // Registered path
        bus4.a  = 4'b1100;
        bus4.b  = 4'b1010;
        bus4.en = 1'b1;
        #1;
        check("reg_y_now", 32'(bus4.y), 32'h8);
        step();
        check("reg_y_q",  32'(bus4.y_q),    32'h8);
        check("reg_rise", 32'(bus4.y_rise), 32'h1);
        step();
        check("reg_rise_off", 32'(bus4.y_rise), 32'h0);

        // Enable hold
        bus4.en = 1'b0;
        bus4.a  = 4'hF;
        bus4.b  = 4'hF;
        #1;
        check("hold_y",   32'(bus4.y),   32'hF);
        check("hold_y_q", 32'(bus4.y_q), 32'h8);
        step();
        check("hold_y_q2",  32'(bus4.y_q),      32'h8);
        check("hold_cnt",   32'(bus4.ones_cnt), 32'h0);
        check("hold_rise",  32'(bus4.y_rise),   32'h0);
        bus4.en = 1'b1;
        step();
        check("en_y_q", 32'(bus4.y_q),      32'hF);
        check("en_cnt", 32'(bus4.ones_cnt), 32'h1);

        // Saturation
        repeat (20) step();
        check("sat_cnt", 32'(bus4.ones_cnt), 32'd15);
        step();
        check("sat_hold", 32'(bus4.ones_cnt), 32'd15);

        // Bring the count to 5 with y_q = F, then reset between edges.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        repeat (5) step();
        check("pre_rst_cnt", 32'(bus4.ones_cnt), 32'd5);
        check("pre_rst_y_q", 32'(bus4.y_q),      32'hF);
        rst = 1'b1;
        #1;
        check("async_y_q",  32'(bus4.y_q),      32'h0);
        check("async_cnt",  32'(bus4.ones_cnt), 32'h0);
        check("async_rise", 32'(bus4.y_rise),   32'h0);
        check("async_y",    32'(bus4.y),        32'hF);

        // Release with a=b=1
        bus4.a = 4'h1;
        bus4.b = 4'h1;
        #1;
        rst = 1'b0;
        step();
        check("rel_y_q",  32'(bus4.y_q),      32'h1);
        check("rel_rise", 32'(bus4.y_rise),   32'h1);
        check("rel_cnt",  32'(bus4.ones_cnt), 32'h0);

        // Randomized traffic with occasional all-ones bias and reset pulses
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus4.a = ALL;
                bus4.b = ALL;
            end else begin
                bus4.a = W'($urandom);
                bus4.b = W'($urandom);
            end
            bus4.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                #2;
                rst = 1'b0;
            end
            step();
        end

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
